// File: rtl/pbuf_loader.sv
// pbuf_loader: streams param/update beats from DDR into banked pbuf words
// and emits a signed per-beat bias sum while in update mode.
module pbuf_loader #(
    parameter int BANK_N    = 4,
    parameter int BATCH     = 4,
    parameter int DATA_W    = 16,
    parameter int BUF_DEPTH = 256,
    parameter int RES_W     = 32,
    localparam int ADDR_W   = $clog2(BUF_DEPTH),
    localparam int WORD_W   = BATCH * DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          done,
    input  logic [2:0]                    conf_mode,
    input  logic [BANK_N-1:0]             conf_grp_sel,
    input  logic [7:0]                    conf_trans_num,
    input  logic [3:0]                    conf_ch_num,
    input  logic [3:0]                    conf_pix_num,
    input  logic [1:0]                    conf_row_num,
    input  logic                          conf_depool,
    input  logic [WORD_W-1:0]             ddr1_data,
    input  logic                          ddr1_valid,
    output logic                          ddr1_ready,
    input  logic [WORD_W-1:0]             ddr2_data,
    input  logic                          ddr2_valid,
    output logic                          ddr2_ready,
    output logic [ADDR_W-1:0]             pbuf_wr_addr,
    output logic [BANK_N-1:0][WORD_W-1:0] pbuf_wr_data,
    output logic [BANK_N-1:0]             pbuf_wr_en,
    output logic                          bias_valid,
    output logic                          bias_new,
    output logic [3:0]                    bias_addr,
    output logic [RES_W-1:0]              bias_data
);
    typedef enum logic [1:0] {IDLE, PARAM, UPDATE, DONE} state_t;
    state_t state, state_n;
    logic [BANK_N-1:0] grp_sel;
    logic [7:0] trans_num, beat;
    logic [3:0] ch_num, pix_num, ch, pix;
    logic [1:0] row_num, row;
    logic depool;
    logic is_param, is_upd, acc, last, drained;
    logic s1_v, s1_new;
    logic [3:0] s1_ch;
    logic [RES_W-1:0] s1_sum, sum;
    logic [BANK_N-1:0] wr_en_n;
    logic [BANK_N-1:0][WORD_W-1:0] wr_data_n;
    logic unused;
    assign unused = &{1'b0, conf_mode[0], ddr2_data};
    assign is_param = state == PARAM;
    assign is_upd = state == UPDATE;
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        ddr1_ready = is_param || (is_upd && ddr2_valid);
        ddr2_ready = is_upd && ddr1_valid;
        acc = (is_param && ddr1_valid) || (is_upd && ddr1_valid && ddr2_valid);
        last = is_param ? beat == trans_num : ch == ch_num && pix == pix_num && row == row_num;
        drained = !(|pbuf_wr_en) && !s1_v && !bias_valid;
        done = state == DONE && drained;
        state_n = state;
        case (state)
            IDLE:          if (start) state_n = conf_mode[2:1] == 2'b10 ? UPDATE : PARAM;
            PARAM, UPDATE: if (acc && last) state_n = DONE;
            default:       if (drained) state_n = IDLE;
        endcase
    end
    // depool expands one ddr1 word into banks 0..3 gated lane-wise by the ddr2 bit mask
    always_comb begin
        sum = '0;
        wr_en_n = '0;
        wr_data_n = '0;
        for (int i = 0; i < BATCH; i++)
            sum = sum + RES_W'($signed(ddr1_data[i*DATA_W +: DATA_W]));
        for (int j = 0; j < BANK_N; j++) begin
            wr_en_n[j] = is_param ? grp_sel[j] : is_upd && (depool ? j < 4 : j == int'({row[0], pix[0]}));
            for (int i = 0; i < BATCH; i++)
                wr_data_n[j][i*DATA_W +: DATA_W] = is_upd && depool && (j >= 4 || !ddr2_data[(j % 4) * BATCH + i]) ?
                    '0 : ddr1_data[i*DATA_W +: DATA_W];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {grp_sel, trans_num, ch_num, pix_num, row_num, depool} <= '0;
            {beat, ch, pix, row} <= '0;
            {s1_v, s1_new, s1_ch, s1_sum} <= '0;
            pbuf_wr_en <= '0;
            pbuf_wr_addr <= '0;
            pbuf_wr_data <= '0;
            {bias_valid, bias_new, bias_addr, bias_data} <= '0;
        end else begin
            if (state == IDLE && start) begin
                grp_sel <= conf_grp_sel;
                trans_num <= conf_trans_num;
                ch_num <= conf_ch_num;
                pix_num <= conf_pix_num;
                row_num <= conf_row_num;
                depool <= conf_depool;
                {beat, ch, pix, row} <= '0;
            end else if (acc) begin
                beat <= beat + 1'b1;
                ch <= ch == ch_num ? '0 : ch + 1'b1;
                pix <= ch != ch_num ? pix : pix == pix_num ? '0 : pix + 1'b1;
                row <= ch == ch_num && pix == pix_num ? row + 1'b1 : row;
            end
            pbuf_wr_en <= acc ? wr_en_n : '0;
            if (acc) begin
                pbuf_wr_addr <= is_param ? ADDR_W'(beat) : ADDR_W'({ch, row[1], pix[3:1]});
                pbuf_wr_data <= wr_data_n;
                s1_sum <= sum;
                s1_ch <= ch;
                s1_new <= pix == '0 && row == '0;
            end
            s1_v <= acc && is_upd;
            bias_valid <= s1_v;
            bias_new <= s1_v && s1_new;
            if (s1_v) begin
                bias_addr <= s1_ch;
                bias_data <= s1_sum;
            end
        end
    end
endmodule

// File: tb/tb_pbuf_loader.sv
// tb_pbuf_loader: cycle-indexed expectation model of pbuf_loader driven by
// directed scenarios, with literal checks pinning each scenario's outcome.
module tb_pbuf_loader;
    localparam int BANK_N = 4, BATCH = 4, DATA_W = 16, BUF_DEPTH = 256, RES_W = 32;
    localparam int ADDR_W = 8, WW = BATCH * DATA_W, NCYC = 1024;
    logic clk = 0, rst = 1, start = 0;
    logic done;
    logic [2:0] conf_mode = 0;
    logic [3:0] conf_grp_sel = 0, conf_ch_num = 0, conf_pix_num = 0;
    logic [7:0] conf_trans_num = 0;
    logic [1:0] conf_row_num = 0;
    logic conf_depool = 0;
    logic [WW-1:0] ddr1_data = 0, ddr2_data = 0;
    logic ddr1_valid = 0, ddr2_valid = 0, ddr1_ready, ddr2_ready;
    logic [ADDR_W-1:0] pbuf_wr_addr;
    logic [BANK_N-1:0][WW-1:0] pbuf_wr_data;
    logic [BANK_N-1:0] pbuf_wr_en;
    logic bias_valid, bias_new;
    logic [3:0] bias_addr;
    logic [RES_W-1:0] bias_data;

    pbuf_loader #(.BANK_N(BANK_N), .BATCH(BATCH), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .RES_W(RES_W)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .conf_mode(conf_mode),
        .conf_grp_sel(conf_grp_sel), .conf_trans_num(conf_trans_num), .conf_ch_num(conf_ch_num),
        .conf_pix_num(conf_pix_num), .conf_row_num(conf_row_num), .conf_depool(conf_depool),
        .ddr1_data(ddr1_data), .ddr1_valid(ddr1_valid), .ddr1_ready(ddr1_ready),
        .ddr2_data(ddr2_data), .ddr2_valid(ddr2_valid), .ddr2_ready(ddr2_ready),
        .pbuf_wr_addr(pbuf_wr_addr), .pbuf_wr_data(pbuf_wr_data), .pbuf_wr_en(pbuf_wr_en),
        .bias_valid(bias_valid), .bias_new(bias_new), .bias_addr(bias_addr), .bias_data(bias_data));

    always #5 clk = ~clk;

    int n_err = 0, n_chk = 0, cyc = 0;
    bit auto_data = 0;
    logic [BANK_N-1:0] e_en [NCYC];
    logic [ADDR_W-1:0] e_addr [NCYC];
    logic [BANK_N-1:0][WW-1:0] e_data [NCYC];
    logic e_bv [NCYC], e_bn [NCYC], e_done [NCYC];
    logic [3:0] e_ba [NCYC];
    logic [RES_W-1:0] e_bd [NCYC];
    bit m_act = 0, m_upd = 0, m_dp = 0;
    int m_k = 0, m_idle_from = 0, m_tn = 0, m_cn = 0, m_pn = 0, m_rn = 0;
    logic [3:0] m_grp = 0;
    logic [3:0] lg_en [$];
    logic [ADDR_W-1:0] lg_addr [$];
    logic [BANK_N-1:0][WW-1:0] lg_data [$];
    int lg_cyc [$], lg_done [$];
    logic [RES_W-1:0] lg_bd [$];
    logic lg_bn [$];
    logic [3:0] t2_en [8] = '{1, 1, 2, 2, 4, 4, 8, 8};
    logic t2_bn [8] = '{1, 1, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    function automatic logic [WW-1:0] gen(int c);
        logic [WW-1:0] d;
        for (int i = 0; i < BATCH; i++) d[i*DATA_W +: DATA_W] = DATA_W'(c * (i + 3) - 50 * i);
        return d;
    endfunction

    // expected outputs are scheduled by cycle: write in the acceptance cycle's successor, bias one later
    always @(posedge clk) begin : model
        int k, ch, pix, row, s, d;
        bit last;
        cyc++;
        if (rst) begin
            m_act = 0;
            m_idle_from = cyc;
            for (int c = cyc; c < NCYC; c++) begin
                e_en[c] = '0; e_bv[c] = 0; e_bn[c] = 0; e_done[c] = 0;
            end
        end else if (m_act && ddr1_valid && (!m_upd || ddr2_valid)) begin
            k = m_k;
            m_k++;
            e_data[cyc] = {BANK_N{ddr1_data}};
            if (m_upd) begin
                ch = k % (m_cn + 1);
                pix = (k / (m_cn + 1)) % (m_pn + 1);
                row = k / ((m_cn + 1) * (m_pn + 1));
                e_addr[cyc] = ADDR_W'(ch * 16 + (row / 2) * 8 + pix / 2);
                e_en[cyc] = m_dp ? 4'b1111 : 4'(1 << ((row % 2) * 2 + pix % 2));
                if (m_dp)
                    for (int j = 0; j < 4; j++)
                        for (int i = 0; i < BATCH; i++)
                            if (!ddr2_data[j*BATCH+i]) e_data[cyc][j][i*DATA_W +: DATA_W] = '0;
                s = 0;
                for (int i = 0; i < BATCH; i++) s += $signed(ddr1_data[i*DATA_W +: DATA_W]);
                e_bv[cyc+1] = 1;
                e_bd[cyc+1] = s;
                e_ba[cyc+1] = 4'(ch);
                e_bn[cyc+1] = pix == 0 && row == 0;
                last = k == (m_cn + 1) * (m_pn + 1) * (m_rn + 1) - 1;
                d = cyc + 2;
            end else begin
                e_addr[cyc] = ADDR_W'(k);
                e_en[cyc] = m_grp;
                last = k == m_tn;
                d = cyc + 1;
            end
            if (last) begin
                m_act = 0;
                e_done[d] = 1;
                m_idle_from = d + 1;
            end
        end else if (!m_act && start && cyc - 1 >= m_idle_from) begin
            m_act = 1; m_k = 0;
            m_upd = conf_mode[2:1] == 2'b10;
            m_grp = conf_grp_sel; m_tn = conf_trans_num; m_dp = conf_depool;
            m_cn = conf_ch_num; m_pn = conf_pix_num; m_rn = conf_row_num;
        end
    end

    always @(negedge clk) begin
        chk("wr_en", 64'(pbuf_wr_en), 64'(e_en[cyc]));
        if (e_en[cyc] != 0) chk("wr_addr", 64'(pbuf_wr_addr), 64'(e_addr[cyc]));
        for (int j = 0; j < BANK_N; j++)
            if (e_en[cyc][j]) chk("wr_data", pbuf_wr_data[j], e_data[cyc][j]);
        chk("bias_valid", 64'(bias_valid), 64'(e_bv[cyc]));
        chk("bias_new", 64'(bias_new), 64'(e_bn[cyc]));
        if (e_bv[cyc]) begin
            chk("bias_data", 64'(bias_data), 64'(e_bd[cyc]));
            chk("bias_addr", 64'(bias_addr), 64'(e_ba[cyc]));
        end
        chk("done", 64'(done), 64'(e_done[cyc]));
        chk("ddr1_ready", 64'(ddr1_ready), 64'(m_act && (!m_upd || ddr2_valid)));
        chk("ddr2_ready", 64'(ddr2_ready), 64'(m_act && m_upd && ddr1_valid));
        if (|pbuf_wr_en) begin
            lg_en.push_back(pbuf_wr_en); lg_addr.push_back(pbuf_wr_addr);
            lg_data.push_back(pbuf_wr_data); lg_cyc.push_back(cyc);
        end
        if (bias_valid) begin
            lg_bd.push_back(bias_data); lg_bn.push_back(bias_new);
        end
        if (done) lg_done.push_back(cyc);
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (auto_data) begin
                ddr1_data = gen(cyc);
                ddr2_data = gen(cyc + 9);
            end
        end
    endtask

    task automatic go(logic [2:0] md, logic [3:0] grp, logic [7:0] tn, logic [3:0] cn, logic [3:0] pn,
                      logic [1:0] rn, logic dp);
        lg_en.delete(); lg_addr.delete(); lg_data.delete(); lg_cyc.delete();
        lg_done.delete(); lg_bd.delete(); lg_bn.delete();
        conf_mode = md; conf_grp_sel = grp; conf_trans_num = tn;
        conf_ch_num = cn; conf_pix_num = pn; conf_row_num = rn; conf_depool = dp;
        start = 1;
        tick(1);
        start = 0;
        // scramble configuration to show the latched copy is what runs
        conf_mode = ~md; conf_grp_sel = ~grp; conf_trans_num = tn ^ 8'h5a;
        conf_ch_num = ~cn; conf_pix_num = ~pn; conf_row_num = ~rn; conf_depool = ~dp;
    endtask

    task automatic wait_done(int limit);
        int n = 0;
        while ((m_act || cyc < m_idle_from) && n < limit) begin
            tick(1);
            n++;
        end
        n_chk++;
        if (n >= limit) begin
            n_err++;
            $display("FAIL wait_done timeout cyc=%0d limit=%0d", cyc, limit);
        end
        tick(2);
    endtask

    initial begin
        for (int c = 0; c < NCYC; c++) begin
            e_en[c] = '0; e_bv[c] = 0; e_bn[c] = 0; e_done[c] = 0;
        end
        tick(2);
        rst = 0;
        tick(1);

        auto_data = 1; ddr1_valid = 1; ddr2_valid = 0;
        go(3'b000, 4'b0101, 8'd3, 0, 0, 0, 0);
        wait_done(50);
        chk("t1_n_wr", 64'(lg_en.size()), 64'd4);
        for (int i = 0; i < 4 && i < lg_en.size(); i++) begin
            chk("t1_en", 64'(lg_en[i]), 64'b0101);
            chk("t1_addr", 64'(lg_addr[i]), 64'(i));
            chk("t1_consec", 64'(lg_cyc[i] - lg_cyc[0]), 64'(i));
        end
        chk("t1_n_done", 64'(lg_done.size()), 64'd1);
        if (lg_done.size() == 1 && lg_cyc.size() == 4) chk("t1_done_cyc", 64'(lg_done[0]), 64'(lg_cyc[3] + 1));

        auto_data = 0;
        ddr1_data = {16'd4, 16'd3, 16'd2, 16'hffff};
        ddr2_data = '1; ddr1_valid = 1; ddr2_valid = 1;
        go(3'b100, 4'b0000, 8'd0, 4'd1, 4'd1, 2'd1, 1'b0);
        tick(2);
        ddr2_valid = 0;
        tick(3);
        ddr2_valid = 1;
        wait_done(50);
        chk("t2_n_wr", 64'(lg_en.size()), 64'd8);
        for (int i = 0; i < 8 && i < lg_en.size(); i++) begin
            chk("t2_en", 64'(lg_en[i]), 64'(t2_en[i]));
            chk("t2_addr", 64'(lg_addr[i]), 64'(i % 2 * 16));
        end
        if (lg_cyc.size() == 8) chk("t2_stall_gap", 64'(lg_cyc[7] - lg_cyc[0]), 64'd10);
        chk("t2_n_bias", 64'(lg_bd.size()), 64'd8);
        for (int i = 0; i < 8 && i < lg_bd.size(); i++) begin
            chk("t2_bias", 64'(lg_bd[i]), 64'd8);
            chk("t2_bias_new", 64'(lg_bn[i]), 64'(t2_bn[i]));
        end
        chk("t2_n_done", 64'(lg_done.size()), 64'd1);

        ddr1_data = {4{16'd5}};
        ddr2_data = 64'h1;
        go(3'b101, 4'b0000, 8'd0, 4'd0, 4'd0, 2'd0, 1'b1);
        wait_done(50);
        chk("t3_n_wr", 64'(lg_en.size()), 64'd1);
        if (lg_en.size() == 1) begin
            chk("t3_en", 64'(lg_en[0]), 64'b1111);
            chk("t3_bank0", lg_data[0][0], 64'h5);
            for (int j = 1; j < 4; j++) chk("t3_bank_zero", lg_data[0][j], 64'h0);
        end
        if (lg_bd.size() == 1) chk("t3_bias", 64'(lg_bd[0]), 64'd20);

        auto_data = 1; ddr2_valid = 0;
        go(3'b000, 4'b1111, 8'd7, 0, 0, 0, 0);
        tick(2);
        rst = 1;
        tick(1);
        rst = 0;
        tick(4);
        chk("t4_n_wr_before_rst", 64'(lg_en.size()), 64'd2);
        chk("t4_no_done", 64'(lg_done.size()), 64'd0);
        go(3'b000, 4'b0011, 8'd1, 0, 0, 0, 0);
        wait_done(50);
        chk("t4_n_wr_restart", 64'(lg_en.size()), 64'd2);
        if (lg_addr.size() == 2) chk("t4_restart_addr0", 64'(lg_addr[0]), 64'd0);
        chk("t4_n_done", 64'(lg_done.size()), 64'd1);

        go(3'b010, 4'b1000, 8'd255, 0, 0, 0, 0);
        wait_done(600);
        chk("t5_n_wr", 64'(lg_en.size()), 64'd256);
        if (lg_addr.size() == 256) chk("t5_last_addr", 64'(lg_addr[255]), 64'd255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
